// File: rtl/fc_dense_if.sv
// Bus bundle for fc_dense: start handshake, feature/weight/bias reads, result writes.
interface fc_dense_if #(
  parameter int unsigned FAW = 12,
  parameter int unsigned WAW = 15
);
  localparam int unsigned DW = 20;
  localparam int unsigned NW = 4;

  logic           ready;
  logic           busy;
  logic           frd;
  logic [FAW-1:0] faddr;
  logic [DW-1:0]  fdata;
  logic [WAW-1:0] waddr;
  logic [DW-1:0]  wdata;
  logic [NW-1:0]  baddr;
  logic [DW-1:0]  bdata;
  logic           owr;
  logic [NW-1:0]  oaddr;
  logic [DW-1:0]  odata;
  logic [NW-1:0]  class_idx;
  logic           class_valid;

  // System side: issues start, serves the three read-only memories, sinks results.
  modport master (
    output ready, fdata, wdata, bdata,
    input  busy, frd, faddr, waddr, baddr, owr, oaddr, odata, class_idx, class_valid
  );

  // Accelerator side.
  modport slave (
    input  ready, fdata, wdata, bdata,
    output busy, frd, faddr, waddr, baddr, owr, oaddr, odata, class_idx, class_valid
  );
endinterface

// File: rtl/fc_dense.sv
// Fully-connected output stage: N_OUT biased dot products over the flattened map,
// rounded/saturated to Q4.16, written out with a running argmax.
module fc_dense #(
  parameter int unsigned N_IN  = 2048,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned FAW   = 12,
  parameter int unsigned WAW   = 15
) (
  input logic       clk,
  input logic       reset,
  fc_dense_if.slave bus
);

  localparam int unsigned DW   = 20;
  localparam int unsigned PW   = 40;
  localparam int unsigned AW   = 52;
  localparam int unsigned NW   = 4;
  localparam int unsigned FRAC = 16;
  localparam int unsigned RW   = AW - FRAC;

  localparam logic signed [RW-1:0] SAT_HI    = RW'(2 ** (DW - 1) - 1);
  localparam logic signed [RW-1:0] SAT_LO    = ~SAT_HI;
  localparam logic signed [DW-1:0] BEST_INIT = {1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  frd_q, frd_d;
  logic [FAW-1:0]        faddr_q, faddr_d;
  logic [WAW-1:0]        waddr_q, waddr_d;
  logic [NW-1:0]         j_q, j_d;
  logic [1:0]            drain_q, drain_d;
  logic                  owr_q, owr_d;
  logic [NW-1:0]         oaddr_q, oaddr_d;
  logic [DW-1:0]         odata_q, odata_d;
  logic [NW-1:0]         cidx_q, cidx_d;
  logic                  cvalid_q, cvalid_d;
  logic signed [DW-1:0]  best_q, best_d;

  // MAC pipeline: data-valid, operand and product stages plus the accumulator.
  logic                  dv_q, opv_q, pv_q;
  logic signed [DW-1:0]  f_op_q, w_op_q;
  logic signed [PW-1:0]  prod_q;
  logic signed [AW-1:0]  acc_q, acc_d;

  logic [AW-1:0]         bias_ext_c;
  logic [AW-1:0]         prod_ext_c;
  logic signed [RW-1:0]  rnd_c;
  logic signed [DW-1:0]  score_c;

  // Accumulator update and the rounded/saturated view of its next value. The
  // last product lands on the same edge that enters WRITE, so the score is
  // taken from acc_d rather than acc_q.
  always_comb begin
    bias_ext_c = {{(AW - DW - FRAC){bus.bdata[DW-1]}}, bus.bdata, {FRAC{1'b0}}};
    prod_ext_c = {{(AW - PW){prod_q[PW-1]}}, prod_q};
    acc_d      = acc_q;
    if (state_q == S_MAC && faddr_q == '0) begin
      acc_d = bias_ext_c;
    end else if (pv_q) begin
      acc_d = acc_q + prod_ext_c;
    end
    rnd_c   = acc_d[AW-1:FRAC] + RW'(acc_d[FRAC-1]);
    score_c = rnd_c[DW-1:0];
    if (rnd_c > SAT_HI) begin
      score_c = SAT_HI[DW-1:0];
    end else if (rnd_c < SAT_LO) begin
      score_c = SAT_LO[DW-1:0];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    frd_d    = 1'b0;
    faddr_d  = faddr_q;
    waddr_d  = waddr_q;
    j_d      = j_q;
    drain_d  = drain_q;
    owr_d    = 1'b0;
    oaddr_d  = oaddr_q;
    odata_d  = odata_q;
    cidx_d   = cidx_q;
    cvalid_d = 1'b0;
    best_d   = best_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.ready) begin
          state_d = S_BIAS;
          busy_d  = 1'b1;
          j_d     = '0;
          waddr_d = '0;
          best_d  = BEST_INIT;
          cidx_d  = '0;
        end
      end
      S_BIAS: begin
        // baddr mirrors j, so bias data arrives in the first MAC cycle.
        faddr_d = '0;
        frd_d   = 1'b1;
        state_d = S_MAC;
      end
      S_MAC: begin
        waddr_d = waddr_q + WAW'(1);
        faddr_d = faddr_q + FAW'(1);
        if (faddr_q == FAW'(N_IN - 1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          frd_d = 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          state_d = S_WRITE;
          owr_d   = 1'b1;
          oaddr_d = j_q;
          odata_d = score_c;
          if (score_c > best_q) begin
            best_d = score_c;
            cidx_d = j_q;
          end
        end
      end
      S_WRITE: begin
        j_d = j_q + NW'(1);
        if (j_q == NW'(N_OUT - 1)) begin
          state_d  = S_DONE;
          cvalid_d = 1'b1;
        end else begin
          state_d = S_BIAS;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      frd_q    <= 1'b0;
      faddr_q  <= '0;
      waddr_q  <= '0;
      j_q      <= '0;
      drain_q  <= '0;
      owr_q    <= 1'b0;
      oaddr_q  <= '0;
      odata_q  <= '0;
      cidx_q   <= '0;
      cvalid_q <= 1'b0;
      best_q   <= '0;
      dv_q     <= 1'b0;
      opv_q    <= 1'b0;
      pv_q     <= 1'b0;
      f_op_q   <= '0;
      w_op_q   <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      frd_q    <= frd_d;
      faddr_q  <= faddr_d;
      waddr_q  <= waddr_d;
      j_q      <= j_d;
      drain_q  <= drain_d;
      owr_q    <= owr_d;
      oaddr_q  <= oaddr_d;
      odata_q  <= odata_d;
      cidx_q   <= cidx_d;
      cvalid_q <= cvalid_d;
      best_q   <= best_d;
      dv_q     <= frd_q;
      opv_q    <= dv_q;
      pv_q     <= opv_q;
      f_op_q   <= bus.fdata;
      w_op_q   <= bus.wdata;
      prod_q   <= PW'(f_op_q) * PW'(w_op_q);
      acc_q    <= acc_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.frd         = frd_q;
  assign bus.faddr       = faddr_q;
  assign bus.waddr       = waddr_q;
  assign bus.baddr       = j_q;
  assign bus.owr         = owr_q;
  assign bus.oaddr       = oaddr_q;
  assign bus.odata       = odata_q;
  assign bus.class_idx   = cidx_q;
  assign bus.class_valid = cvalid_q;

endmodule
